abs_scheduler: RTL and testbench

- Shares one combinational absolute-value datapath (N-bit, two's complement) between R requesters.
- Round-robin arbitration, valid/ready handshake on each request port.
- One registered result slot with valid/ready toward the consumer, tagged with the requester index and an overflow flag.
- Sits between the register-file operand readers and the single absolute-value unit, so only one datapath instance exists in the design.

---
 rtl/abs_scheduler_pkg.sv | 23 ++
 rtl/abs_scheduler_rr_arbiter.sv | 35 +++
 rtl/absolute_value.sv | 26 ++
 rtl/abs_scheduler.sv | 120 ++++++++++++
 tb/tb_abs_scheduler.sv | 156 +++++++++++++++
 5 files changed

// File: rtl/abs_scheduler_pkg.sv
// Shared types and constant helpers for the absolute-value scheduler slice.
package abs_scheduler_pkg;

   typedef enum logic {
      EMPTY = 1'b0,
      FULL  = 1'b1
   } state_t;

   // Requester index width; a single requester still needs one bit of port.
   function automatic int id_width(input int r);
      if (r <= 1) begin
         return 1;
      end else begin
         return $clog2(r);
      end
   endfunction

   // Most negative two's-complement pattern of an n-bit word, zero-extended.
   function automatic logic [63:0] most_neg(input int n);
      return 64'd1 << (n - 1);
   endfunction

endpackage

// File: rtl/abs_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: search starts at ptr and wraps modulo R.
module rr_arbiter
   import abs_scheduler_pkg::*;
#(
   parameter  int R   = 4,
   localparam int IDW = id_width(R)
) (
   input  logic [R-1:0]   req,
   input  logic [IDW-1:0] ptr,
   output logic [R-1:0]   grant,
   output logic [IDW-1:0] grant_idx
);

   logic found_s;
   int   j_s;

   // First requester at or after the pointer wins.
   always_comb begin
      grant     = '0;
      grant_idx = '0;
      found_s   = 1'b0;
      j_s       = 0;
      for (int k = 0; k < R; k++) begin
         j_s = (int'(ptr) + k) % R;
         if (!found_s && req[j_s]) begin
            grant[j_s] = 1'b1;
            grant_idx  = IDW'(j_s);
            found_s    = 1'b1;
         end else begin
            found_s = found_s;
         end
      end
   end

endmodule

// File: rtl/absolute_value.sv
// Combinational two's-complement absolute value with overflow flag for -2^(N-1).
module absolute_value
   import abs_scheduler_pkg::*;
#(
   parameter int N = 8
) (
   input  logic [N-1:0] number,
   output logic [N-1:0] abs_value,
   output logic         ovf
);

   localparam logic [63:0] MOST_NEG_W = most_neg(N);
   localparam logic [N-1:0] ONE       = {{(N-1){1'b0}}, 1'b1};

   // Negate negative operands; the most negative value wraps to itself.
   always_comb begin
      abs_value = number;
      if (number[N-1]) begin
         abs_value = (~number) + ONE;
      end else begin
         abs_value = number;
      end
      ovf = (number == MOST_NEG_W[N-1:0]);
   end

endmodule

// File: rtl/abs_scheduler.sv
// Shares one absolute-value datapath among R requesters with a registered,
// id-tagged result slot toward a single consumer.
module abs_scheduler
   import abs_scheduler_pkg::*;
#(
   parameter  int N   = 8,
   parameter  int R   = 4,
   localparam int IDW = id_width(R)
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic [R-1:0]   req_valid,
   input  logic [R*N-1:0] req_number,
   output logic [R-1:0]   req_ready,
   output logic           resp_valid,
   input  logic           resp_ready,
   output logic [N-1:0]   resp_abs,
   output logic           resp_ovf,
   output logic [IDW-1:0] resp_id,
   output logic           busy
);

   state_t         state_r;
   logic [IDW-1:0] ptr_r;
   logic [N-1:0]   abs_r;
   logic           ovf_r;
   logic [IDW-1:0] id_r;

   logic           can_accept_s;
   logic [R-1:0]   grant_s;
   logic [IDW-1:0] grant_idx_s;
   logic [R-1:0]   ready_s;
   logic           xfer_s;
   logic [N-1:0]   operand_s;
   logic [N-1:0]   abs_s;
   logic           ovf_s;
   logic [IDW-1:0] ptr_nxt_s;

   // Gated by rst_n so nothing is granted while reset is held.
   assign can_accept_s = rst_n && ((state_r == EMPTY) || resp_ready);

   rr_arbiter #(.R(R)) u_arb (
      .req       (req_valid),
      .ptr       (ptr_r),
      .grant     (grant_s),
      .grant_idx (grant_idx_s)
   );

   // Grant qualification, operand AND-OR mux and pointer advance.
   always_comb begin
      ready_s   = can_accept_s ? grant_s : '0;
      xfer_s    = |(ready_s & req_valid);
      operand_s = '0;
      for (int i = 0; i < R; i++) begin
         if (ready_s[i]) begin
            operand_s = req_number[i*N +: N];
         end else begin
            operand_s = operand_s;
         end
      end
      if (grant_idx_s == IDW'(R - 1)) begin
         ptr_nxt_s = '0;
      end else begin
         ptr_nxt_s = grant_idx_s + IDW'(1);
      end
   end

   absolute_value #(.N(N)) u_abs (
      .number    (operand_s),
      .abs_value (abs_s),
      .ovf       (ovf_s)
   );

   // Slot FSM: load on transfer, drain on consumer handshake, otherwise hold.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= EMPTY;
         ptr_r   <= '0;
         abs_r   <= '0;
         ovf_r   <= 1'b0;
         id_r    <= '0;
      end else begin
         if (xfer_s) begin
            abs_r <= abs_s;
            ovf_r <= ovf_s;
            id_r  <= grant_idx_s;
            ptr_r <= ptr_nxt_s;
         end else begin
            ptr_r <= ptr_r;
         end
         case (state_r)
            EMPTY: begin
               if (xfer_s) begin
                  state_r <= FULL;
               end else begin
                  state_r <= EMPTY;
               end
            end
            FULL: begin
               if (xfer_s) begin
                  state_r <= FULL;
               end else if (resp_ready) begin
                  state_r <= EMPTY;
               end else begin
                  state_r <= FULL;
               end
            end
            default: state_r <= EMPTY;
         endcase
      end
   end

   assign req_ready  = ready_s;
   assign resp_valid = (state_r == FULL);
   assign busy       = (state_r == FULL);
   assign resp_abs   = abs_r;
   assign resp_ovf   = ovf_r;
   assign resp_id    = id_r;

endmodule

// File: tb/tb_abs_scheduler.sv
// Directed bench for abs_scheduler (N=8, R=4) with hand-computed expectations.
module tb_abs_scheduler;

   localparam int N   = 8;
   localparam int R   = 4;
   localparam int IDW = 2;

   logic           clk;
   logic           rst_n;
   logic [R-1:0]   req_valid;
   logic [R*N-1:0] req_number;
   logic [R-1:0]   req_ready;
   logic           resp_valid;
   logic           resp_ready;
   logic [N-1:0]   resp_abs;
   logic           resp_ovf;
   logic [IDW-1:0] resp_id;
   logic           busy;

   int total = 0;
   int passed = 0;

   abs_scheduler #(.N(N), .R(R)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req_valid  (req_valid),
      .req_number (req_number),
      .req_ready  (req_ready),
      .resp_valid (resp_valid),
      .resp_ready (resp_ready),
      .resp_abs   (resp_abs),
      .resp_ovf   (resp_ovf),
      .resp_id    (resp_id),
      .busy       (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   task automatic cyc();
      @(posedge clk);
      #2;
   endtask

   task automatic chk_resp(input string tag, input logic [7:0] abs_e, input logic ovf_e,
                           input logic [1:0] id_e);
      chk({tag, "_valid"}, 32'(resp_valid), 32'd1);
      chk({tag, "_abs"},   32'(resp_abs),   32'(abs_e));
      chk({tag, "_ovf"},   32'(resp_ovf),   32'(ovf_e));
      chk({tag, "_id"},    32'(resp_id),    32'(id_e));
   endtask

   initial begin
      rst_n      = 1'b0;
      req_valid  = 4'b1111;
      req_number = {8'h80, 8'hFB, 8'hFF, 8'h03};
      resp_ready = 1'b1;
      repeat (2) cyc();
      #1;
      chk("rst_ready", 32'(req_ready),  32'd0);
      chk("rst_valid", 32'(resp_valid), 32'd0);
      chk("rst_busy",  32'(busy),       32'd0);
      chk("rst_abs",   32'(resp_abs),   32'd0);
      chk("rst_ovf",   32'(resp_ovf),   32'd0);
      chk("rst_id",    32'(resp_id),    32'd0);

      // Release: requester 0 first, then strict rotation 1,2,3,0 at full rate.
      rst_n = 1'b1;
      #1;
      chk("rel_ready", 32'(req_ready), 32'b0001);
      cyc();
      chk_resp("rr0", 8'h03, 1'b0, 2'd0);
      chk("rr0_ready", 32'(req_ready), 32'b0010);
      cyc();
      chk_resp("rr1", 8'h01, 1'b0, 2'd1);
      chk("rr1_ready", 32'(req_ready), 32'b0100);
      cyc();
      chk_resp("rr2", 8'h05, 1'b0, 2'd2);
      chk("rr2_ready", 32'(req_ready), 32'b1000);
      cyc();
      chk_resp("rr3", 8'h80, 1'b1, 2'd3);
      chk("rr3_ready", 32'(req_ready), 32'b0001);
      cyc();
      chk_resp("rr4", 8'h03, 1'b0, 2'd0);

      // Single requester 2 with -5; pointer is at 1.
      req_valid = 4'b0100;
      #1;
      chk("single_ready", 32'(req_ready), 32'b0100);
      cyc();
      chk_resp("single", 8'h05, 1'b0, 2'd2);

      // No requests: slot drains.
      req_valid = 4'b0000;
      #1;
      chk("idle_ready", 32'(req_ready), 32'd0);
      cyc();
      chk("drain_valid", 32'(resp_valid), 32'd0);
      chk("drain_busy",  32'(busy),       32'd0);

      // Zero and +127 operands.
      req_valid  = 4'b0001;
      req_number = {8'h80, 8'hFB, 8'hFF, 8'h00};
      cyc();
      chk_resp("zero", 8'h00, 1'b0, 2'd0);
      req_valid  = 4'b0010;
      req_number = {8'h80, 8'hFB, 8'h7F, 8'h00};
      cyc();
      chk_resp("pos127", 8'h7F, 1'b0, 2'd1);

      // Backpressure: slot holds, nothing granted.
      resp_ready = 1'b0;
      req_valid  = 4'b1111;
      req_number = {8'h80, 8'hFB, 8'hFF, 8'h03};
      #1;
      chk("bp_ready0", 32'(req_ready), 32'd0);
      for (int k = 0; k < 3; k++) begin
         cyc();
         chk("bp_ready", 32'(req_ready), 32'd0);
         chk_resp("bp_hold", 8'h7F, 1'b0, 2'd1);
      end
      resp_ready = 1'b1;
      #1;
      chk("bp_release_ready", 32'(req_ready), 32'b0100);
      cyc();
      chk_resp("bp_refill", 8'h05, 1'b0, 2'd2);

      // Async reset while FULL and stalled; pointer (now 3) returns to 0.
      resp_ready = 1'b0;
      req_valid  = 4'b0000;
      #1;
      rst_n = 1'b0;
      #1;
      chk("arst_valid", 32'(resp_valid), 32'd0);
      chk("arst_busy",  32'(busy),       32'd0);
      chk("arst_abs",   32'(resp_abs),   32'd0);
      cyc();
      rst_n      = 1'b1;
      req_valid  = 4'b1111;
      resp_ready = 1'b1;
      #1;
      chk("arst_ptr_ready", 32'(req_ready), 32'b0001);
      cyc();
      chk_resp("arst_first", 8'h03, 1'b0, 2'd0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
